// File: rtl/filter_5x5_frame_ctrl_if.sv
// Video timing bundle seen by the 5x5 filter core input.
// The video source drives it (master) and the frame controller monitors it (slave).
interface filter_5x5_frame_ctrl_if;
    logic vs_i;   // 0 = vertical blank, 1 = frame active
    logic hs_i;   // 0 = line period, 1 = horizontal blank
    logic de_i;   // pixel valid

    modport master (output vs_i, hs_i, de_i);
    modport slave  (input  vs_i, hs_i, de_i);
endinterface

// File: rtl/filter_5x5_frame_ctrl.sv
// Frame-level controller for the 5x5 window filter core.
// It measures each frame's active width and height from vs/hs/de and checks them
// against the line-buffer depth and the window size. It switches the core's bypass
// only at frame start, and publishes geometry and error flags once per frame.
// Timing: vs/hs/de are sampled once. All edge detection and pixel counting work on
// these sampled copies, so line ends, frame ends and pixels stay aligned.
// state_o exposes the FSM state (0 = SYNC, 1 = VBLANK, 2 = ACTIVE).
module filter_5x5_frame_ctrl #(
    parameter int LINE_SIZE_MAX = 1024,
    parameter int WIN           = 5,
    parameter bit AUTO_BYPASS   = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    filter_5x5_frame_ctrl_if.slave  vid,
    input  logic                    bypass_req,
    output logic                    bypass_o,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic                    err_width,
    output logic                    err_height,
    output logic                    err_ragged,
    output logic [CNT_W-1:0]        width_o,
    output logic [CNT_W-1:0]        height_o,
    output logic [CNT_W-1:0]        out_width_o,
    output logic [CNT_W-1:0]        out_height_o,
    output logic [CNT_W-1:0]        frame_cnt_o,
    output logic [1:0]              state_o
);

    localparam logic [CNT_W-1:0] PIX_SAT = CNT_W'(LINE_SIZE_MAX + 1);
    localparam logic [CNT_W-1:0] LMAX_C  = CNT_W'(LINE_SIZE_MAX);
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WIN);
    localparam logic [CNT_W-1:0] ADJ_C   = CNT_W'(WIN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SYNC = 2'd0, VBLANK = 2'd1, ACTIVE = 2'd2} state_t;

    state_t           state, state_n;
    logic             vs_q, vs_d, hs_q, hs_d, de_q;
    logic [CNT_W-1:0] pix_cnt, pix_n;
    logic [CNT_W-1:0] ref_w, ref_n;
    logic [CNT_W-1:0] line_cnt, line_n;
    logic             ragged, rag_n;
    logic             force_q;
    logic             load_bypass, publish;
    logic             frame_start, frame_end, line_end, pix_inc, close_line;
    logic             e_w, e_h, ok_n;

    assign state_o     = state;
    assign frame_start = vs_q & ~vs_d;
    assign frame_end   = ~vs_q & vs_d;
    assign line_end    = hs_q & ~hs_d;
    assign pix_inc     = de_q & vs_q;
    // A frame end closes a still-open line, so the last line counts even when
    // hs never rises before vs falls.
    assign close_line  = (line_end | frame_end) & (pix_cnt != '0);

    // Sample the video timing; reset to "active/blank" so a frame already in
    // progress at reset release never produces a false frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b1;
            vs_d <= 1'b1;
            hs_q <= 1'b1;
            hs_d <= 1'b1;
            de_q <= 1'b0;
        end else begin
            vs_q <= vid.vs_i;
            vs_d <= vs_q;
            hs_q <= vid.hs_i;
            hs_d <= hs_q;
            de_q <= vid.de_i;
        end
    end

    // Next-state logic plus next values of the per-frame measurement counters.
    always_comb begin
        state_n     = state;
        pix_n       = pix_cnt;
        ref_n       = ref_w;
        line_n      = line_cnt;
        rag_n       = ragged;
        load_bypass = 1'b0;
        publish     = 1'b0;
        case (state)
            SYNC: begin
                if (!vs_q) state_n = VBLANK;
            end
            VBLANK: begin
                if (frame_start) begin
                    state_n     = ACTIVE;
                    load_bypass = 1'b1;
                    pix_n       = CNT_W'(pix_inc);
                    ref_n       = '0;
                    line_n      = '0;
                    rag_n       = 1'b0;
                end
            end
            ACTIVE: begin
                if (close_line) begin
                    if (line_cnt == '0) ref_n = pix_cnt;
                    else if (pix_cnt != ref_w) rag_n = 1'b1;
                    if (line_cnt != CNT_MAX) line_n = line_cnt + 1'b1;
                    // A pixel arriving in the line-end cycle belongs to the next line.
                    pix_n = CNT_W'(pix_inc);
                end else if (pix_inc && (pix_cnt != PIX_SAT)) begin
                    pix_n = pix_cnt + 1'b1;
                end
                if (frame_end) begin
                    state_n = VBLANK;
                    publish = 1'b1;
                end
            end
            default: state_n = SYNC;
        endcase
    end

    // Frame verdict from the counters as they stand once the final line is closed.
    always_comb begin
        e_w  = (ref_n < WIN_C) | (ref_n > LMAX_C);
        e_h  = (line_n < WIN_C);
        ok_n = ~(e_w | e_h | rag_n);
    end

    // State register and per-frame measurement counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SYNC;
            pix_cnt  <= '0;
            ref_w    <= '0;
            line_cnt <= '0;
            ragged   <= 1'b0;
        end else begin
            state    <= state_n;
            pix_cnt  <= pix_n;
            ref_w    <= ref_n;
            line_cnt <= line_n;
            ragged   <= rag_n;
        end
    end

    // Publish results at frame end. Bypass changes only at frame start, with a
    // forced bypass after a bad frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_o     <= 1'b1;
            force_q      <= 1'b0;
            frame_done   <= 1'b0;
            frame_ok     <= 1'b0;
            err_width    <= 1'b0;
            err_height   <= 1'b0;
            err_ragged   <= 1'b0;
            width_o      <= '0;
            height_o     <= '0;
            out_width_o  <= '0;
            out_height_o <= '0;
            frame_cnt_o  <= '0;
        end else begin
            frame_done <= publish;
            if (load_bypass) bypass_o <= bypass_req | (AUTO_BYPASS & force_q);
            if (publish) begin
                width_o      <= ref_n;
                height_o     <= line_n;
                err_width    <= e_w;
                err_height   <= e_h;
                err_ragged   <= rag_n;
                frame_ok     <= ok_n;
                force_q      <= ~ok_n;
                out_width_o  <= ok_n ? (ref_n - ADJ_C) : '0;
                out_height_o <= ok_n ? (line_n - ADJ_C) : '0;
                frame_cnt_o  <= frame_cnt_o + 1'b1;
            end
        end
    end

endmodule
